// File: rtl/axi4_ram_tester_if.sv
// AXI4 bus bundle between the RAM tester (master) and the SRAM slave.
// Latency: none, wires only.
// Backpressure: carried by the VALID/READY pairs of each channel.
// Ports: AW, W, B, AR and R channel signals; modports master and slave.
interface axi4_ram_tester_if #(
    parameter int AXI4_AWIDTH  = 32,
    parameter int AXI4_IDWIDTH = 4
);
    logic [AXI4_IDWIDTH-1:0] AWID;
    logic [AXI4_AWIDTH-1:0]  AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic [3:0]              AWCACHE;
    logic [2:0]              AWPROT;
    logic [1:0]              AWLOCK;
    logic                    AWVALID;
    logic                    AWREADY;

    logic [63:0]             WDATA;
    logic [7:0]              WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;

    logic [AXI4_IDWIDTH-1:0] BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    logic [AXI4_IDWIDTH-1:0] ARID;
    logic [AXI4_AWIDTH-1:0]  ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic [3:0]              ARCACHE;
    logic [2:0]              ARPROT;
    logic [1:0]              ARLOCK;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [AXI4_IDWIDTH-1:0] RID;
    logic [63:0]             RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT, AWLOCK, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, ARLOCK, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT, AWLOCK, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, ARLOCK, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_ram_tester.sv
// AXI4 RAM tester: writes {~g,g} over the window in INCR bursts, reads it back, counts errors.
// Latency: AWVALID the cycle after START; one transaction outstanding; zero-wait burst = 1+BURST_LEN+1 cycles.
// Backpressure: every VALID and its payload are held until READY; B/R are always accepted in their phase.
// Ports: ACLK, ARESETN (sync, active-low), START in; BUSY, DONE, PASS, ERR_CNT out; axi = AXI4 master.
// Build option: define AXI4_RAM_TESTER_RDCHK_EN to compile in the read-back/compare phase (AR, R).
module axi4_ram_tester #(
    parameter int                     AXI4_AWIDTH  = 32,
    parameter int                     AXI4_IDWIDTH = 4,
    parameter logic [AXI4_AWIDTH-1:0] BASE_ADDR    = '0,
    parameter int                     BURST_LEN    = 16,
    parameter int                     NUM_BURSTS   = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [15:0]       ERR_CNT,
    axi4_ram_tester_if.master axi
);
    localparam logic [7:0]             LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [15:0]            LAST_BURST  = 16'(NUM_BURSTS - 1);
    localparam logic [AXI4_AWIDTH-1:0] BURST_BYTES = AXI4_AWIDTH'(BURST_LEN * 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
`ifdef AXI4_RAM_TESTER_RDCHK_EN
        S_AR,
        S_R,
`endif
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [AXI4_AWIDTH-1:0] addr_q, addr_d;
    logic [15:0]            burst_q, burst_d;
    logic [7:0]             beat_q, beat_d;
    logic [31:0]            g_q, g_d;
    logic [15:0]            err_q, err_d;
    logic                   err_inc;

    function automatic logic [63:0] pattern(input logic [31:0] idx);
        return {~idx, idx};
    endfunction

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            g_q     <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            g_q     <= g_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        g_d     = g_q;
        err_d   = err_q;
        err_inc = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_AW;
                    addr_d  = BASE_ADDR;
                    burst_d = '0;
                    beat_d  = '0;
                    g_d     = '0;
                    err_d   = '0;
                end
            end
            S_AW: if (axi.AWREADY) state_d = S_W;
            S_W: begin
                if (axi.WREADY) begin
                    g_d = g_q + 32'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_B: begin
                if (axi.BVALID) begin
                    err_inc = (axi.BRESP != 2'b00) || (axi.BID != '0);
                    if (burst_q == LAST_BURST) begin
                        // Write phase over: the read phase restarts at burst 0, beat index 0.
                        burst_d = '0;
                        g_d     = '0;
                        addr_d  = BASE_ADDR;
`ifdef AXI4_RAM_TESTER_RDCHK_EN
                        state_d = S_AR;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        burst_d = burst_q + 16'd1;
                        addr_d  = addr_q + BURST_BYTES;
                        state_d = S_AW;
                    end
                end
            end
`ifdef AXI4_RAM_TESTER_RDCHK_EN
            S_AR: if (axi.ARREADY) state_d = S_R;
            S_R: begin
                if (axi.RVALID) begin
                    // Any combination of faults on one beat counts once; the burst length
                    // is ours, so a misplaced RLAST never shortens or stretches it.
                    err_inc = (axi.RDATA != pattern(g_q)) || (axi.RRESP != 2'b00) ||
                              (axi.RID != '0) || (axi.RLAST != (beat_q == LAST_BEAT));
                    g_d = g_q + 32'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (burst_q == LAST_BURST) begin
                            state_d = S_DONE;
                        end else begin
                            burst_d = burst_q + 16'd1;
                            addr_d  = addr_q + BURST_BYTES;
                            state_d = S_AR;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (err_inc && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    // Payloads are zero outside their phase and only move on a handshake, so they are stable while VALID.
    assign axi.AWVALID = (state_q == S_AW);
    assign axi.AWADDR  = axi.AWVALID ? addr_q : '0;
    assign axi.AWID    = '0;
    assign axi.AWLEN   = LAST_BEAT;
    assign axi.AWSIZE  = 3'b011;
    assign axi.AWBURST = 2'b01;
    assign axi.AWCACHE = 4'b0011;
    assign axi.AWPROT  = 3'b000;
    assign axi.AWLOCK  = 2'b00;

    assign axi.WVALID  = (state_q == S_W);
    assign axi.WDATA   = axi.WVALID ? pattern(g_q) : '0;
    assign axi.WSTRB   = 8'hFF;
    assign axi.WLAST   = axi.WVALID && (beat_q == LAST_BEAT);
    assign axi.BREADY  = (state_q == S_B);

`ifdef AXI4_RAM_TESTER_RDCHK_EN
    assign axi.ARVALID = (state_q == S_AR);
    assign axi.ARADDR  = axi.ARVALID ? addr_q : '0;
    assign axi.ARID    = '0;
    assign axi.ARLEN   = LAST_BEAT;
    assign axi.ARSIZE  = 3'b011;
    assign axi.ARBURST = 2'b01;
    assign axi.ARCACHE = 4'b0011;
    assign axi.ARPROT  = 3'b000;
    assign axi.ARLOCK  = 2'b00;
    assign axi.RREADY  = (state_q == S_R);
`else
    assign axi.ARVALID = 1'b0;
    assign axi.ARADDR  = '0;
    assign axi.ARID    = '0;
    assign axi.ARLEN   = '0;
    assign axi.ARSIZE  = '0;
    assign axi.ARBURST = '0;
    assign axi.ARCACHE = '0;
    assign axi.ARPROT  = '0;
    assign axi.ARLOCK  = '0;
    assign axi.RREADY  = 1'b0;
    logic rd_unused;
    assign rd_unused = ^{axi.ARREADY, axi.RID, axi.RDATA, axi.RRESP, axi.RLAST, axi.RVALID};
`endif

    assign BUSY    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign DONE    = (state_q == S_DONE);
    assign PASS    = DONE && (err_q == 16'd0);
    assign ERR_CNT = err_q;
endmodule

// File: tb/tb_axi4_ram_tester.sv
// Directed bench for axi4_ram_tester against a behavioural 512x64 AXI4 SRAM slave.
// The slave can stall each channel, flip RDATA on one read beat, return BRESP=SLVERR and move RLAST early.
module tb_axi4_ram_tester;
`ifdef AXI4_RAM_TESTER_RDCHK_EN
    localparam int EXP_CYC = 576 + 544;   // 32*(1+16+1) write + 32*(1+16) read cycles
    localparam int EXP_E4  = 2;           // SLVERR on burst 3 + early RLAST on read burst 0
`else
    localparam int EXP_CYC = 576;
    localparam int EXP_E4  = 1;
`endif

    logic        ACLK;
    logic        ARESETN;
    logic        START;
    logic        BUSY, DONE, PASS;
    logic [15:0] ERR_CNT;

    axi4_ram_tester_if #(.AXI4_AWIDTH(32), .AXI4_IDWIDTH(4)) axi ();

    axi4_ram_tester #(
        .AXI4_AWIDTH(32), .AXI4_IDWIDTH(4), .BASE_ADDR(32'h0), .BURST_LEN(16), .NUM_BURSTS(32)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .START(START),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT),
        .axi(axi)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- slave model ----------------
    logic [63:0] mem [0:511];
    logic        aw_stall, w_stall, ar_stall, r_stall, mem_clr;
    int          bresp_err_burst, corrupt_g, rlast_early_burst;
    logic [8:0]  wr_idx, rd_idx;
    logic [7:0]  rd_beat, rd_len;
    logic        rd_active, rv_gate;
    int          wr_burst, rd_burst, rd_g;
    logic        ar_seen, stab_err;
    logic        aw_pend, w_pend, ar_pend;
    logic [31:0] aw_hold, ar_hold;
    logic [64:0] w_hold;

    assign axi.BID    = '0;
    assign axi.RID    = '0;
    assign axi.RRESP  = 2'b00;
    assign axi.RVALID = rd_active && rv_gate;
    assign axi.RDATA  = mem[rd_idx] ^ ((rd_g == corrupt_g) ? 64'h1 : 64'h0);
    assign axi.RLAST  = (rd_beat == rd_len) ||
                        ((rd_burst == rlast_early_burst) && (rd_beat == rd_len - 8'd1));

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            axi.AWREADY <= 1'b0;
            axi.WREADY  <= 1'b0;
            axi.BVALID  <= 1'b0;
            axi.BRESP   <= 2'b00;
            axi.ARREADY <= 1'b0;
            rd_active   <= 1'b0;
            rv_gate     <= 1'b0;
            aw_pend     <= 1'b0;
            w_pend      <= 1'b0;
            ar_pend     <= 1'b0;
        end else begin
            axi.AWREADY <= aw_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi.WREADY  <= w_stall  ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi.ARREADY <= ar_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            rv_gate     <= r_stall  ? ($urandom_range(0, 3) != 0) : 1'b1;

            if (axi.AWVALID && axi.AWREADY) wr_idx <= axi.AWADDR[11:3];
            if (axi.BVALID && axi.BREADY) axi.BVALID <= 1'b0;
            if (axi.WVALID && axi.WREADY) begin
                mem[wr_idx] <= axi.WDATA;
                wr_idx      <= wr_idx + 9'd1;
                if (axi.WLAST) begin
                    axi.BVALID <= 1'b1;
                    axi.BRESP  <= (wr_burst == bresp_err_burst) ? 2'b10 : 2'b00;
                    wr_burst   <= wr_burst + 1;
                end
            end

            if (axi.ARVALID) ar_seen <= 1'b1;
            if (axi.ARVALID && axi.ARREADY) begin
                rd_idx    <= axi.ARADDR[11:3];
                rd_beat   <= 8'd0;
                rd_len    <= axi.ARLEN;
                rd_active <= 1'b1;
            end
            if (axi.RVALID && axi.RREADY) begin
                rd_idx  <= rd_idx + 9'd1;
                rd_beat <= rd_beat + 8'd1;
                rd_g    <= rd_g + 1;
                if (rd_beat == rd_len) begin
                    rd_active <= 1'b0;
                    rd_burst  <= rd_burst + 1;
                end
            end

            // A stalled VALID must still be high with the same payload on the next edge.
            if (aw_pend && (!axi.AWVALID || axi.AWADDR != aw_hold)) stab_err <= 1'b1;
            if (w_pend && (!axi.WVALID || {axi.WLAST, axi.WDATA} != w_hold)) stab_err <= 1'b1;
            if (ar_pend && (!axi.ARVALID || axi.ARADDR != ar_hold)) stab_err <= 1'b1;
            aw_pend <= axi.AWVALID && !axi.AWREADY;
            w_pend  <= axi.WVALID && !axi.WREADY;
            ar_pend <= axi.ARVALID && !axi.ARREADY;
            aw_hold <= axi.AWADDR;
            w_hold  <= {axi.WLAST, axi.WDATA};
            ar_hold <= axi.ARADDR;
        end
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 64'h0;
            wr_burst <= 0;
            rd_burst <= 0;
            rd_g     <= 0;
            ar_seen  <= 1'b0;
            stab_err <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        mem_clr = 1'b1;
        @(negedge ACLK);
        mem_clr = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (DONE !== 1'b1 && cyc < budget) begin
            @(negedge ACLK);
            cyc++;
        end
    endtask

    task automatic check_mem(input string tag);
        int bad;
        logic [31:0] gi;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            gi = 32'(i);
            if (mem[i] !== {~gi, gi}) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    int cyc;

    initial begin
        ARESETN = 1'b0; START = 1'b0; mem_clr = 1'b0;
        aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0; r_stall = 1'b0;
        bresp_err_burst = -1; corrupt_g = -1; rlast_early_burst = -1;
        repeat (3) @(negedge ACLK);

        // reset values
        check("rst_valids", {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY, axi.WLAST}, 0);
        check("rst_status", {BUSY, DONE, PASS}, 0);
        check("rst_errcnt", ERR_CNT, 0);
        check("rst_payload", {axi.AWADDR, axi.ARADDR}, 0);
        check("rst_wdata", axi.WDATA, 0);
        ARESETN = 1'b1;

        // pass 1: zero-wait slave
        clear_slave();
        pulse_start();
        check("p1_awvalid_rise", axi.AWVALID, 1);
        check("p1_busy", BUSY, 1);
        check("p1_aw_payload", {axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST}, {32'h0, 8'd15, 3'b011, 2'b01});
        @(negedge ACLK);
        check("p1_wvalid_rise", {axi.AWVALID, axi.WVALID}, 2'b01);
        check("p1_wdata0", axi.WDATA, 64'hFFFFFFFF_00000000);
        wait_done(3000, cyc);
        check("p1_cycles", 64'(cyc + 1), 64'(EXP_CYC));
        check("p1_status", {BUSY, DONE, PASS}, 3'b011);
        check("p1_errcnt", ERR_CNT, 0);
        check("p1_mem5", mem[5], 64'hFFFFFFFA_00000005);
        check_mem("p1_mem_all");
        check("p1_b_count", 64'(wr_burst), 64'd32);
`ifdef AXI4_RAM_TESTER_RDCHK_EN
        check("p1_r_count", 64'(rd_burst), 64'd32);
`else
        check("p1_arvalid_never", ar_seen, 0);
`endif

        // pass 2: random stalls on every channel
        clear_slave();
        aw_stall = 1'b1; w_stall = 1'b1; ar_stall = 1'b1; r_stall = 1'b1;
        pulse_start();
        wait_done(20000, cyc);
        aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0; r_stall = 1'b0;
        check("p2_status", {DONE, PASS}, 2'b11);
        check("p2_errcnt", ERR_CNT, 0);
        check_mem("p2_mem_all");
        check("p2_payload_stable", stab_err, 0);

`ifdef AXI4_RAM_TESTER_RDCHK_EN
        // pass 3: one corrupted read beat
        clear_slave();
        corrupt_g = 37;
        pulse_start();
        wait_done(3000, cyc);
        corrupt_g = -1;
        check("p3_status", {DONE, PASS}, 2'b10);
        check("p3_errcnt", ERR_CNT, 1);
`endif

        // pass 4: SLVERR on write burst 3 (and early RLAST on read burst 0)
        clear_slave();
        bresp_err_burst = 3;
`ifdef AXI4_RAM_TESTER_RDCHK_EN
        rlast_early_burst = 0;
`endif
        pulse_start();
        check("p4_done_cleared", {DONE, BUSY, ERR_CNT}, {1'b0, 1'b1, 16'd0});
        wait_done(3000, cyc);
        bresp_err_burst = -1; rlast_early_burst = -1;
        check("p4_status", {DONE, PASS}, 2'b10);
        check("p4_errcnt", ERR_CNT, 64'(EXP_E4));
        check_mem("p4_mem_all");

        // reset while DONE with errors recorded
        ARESETN = 1'b0;
        @(negedge ACLK);
        check("rst_done_status", {BUSY, DONE, PASS, ERR_CNT}, 0);
        ARESETN = 1'b1;

        // pass 5: extra START while busy, then reset mid-W
        clear_slave();
        pulse_start();
        repeat (3) @(negedge ACLK);
        START = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        @(negedge ACLK);
        check("p5_start_ignored", {axi.AWVALID, axi.WVALID, BUSY}, 3'b011);
        check("p5_wdata4", axi.WDATA, 64'hFFFFFFFB_00000004);
        ARESETN = 1'b0;
        @(negedge ACLK);
        check("p5_rst_valids", {axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY}, 0);
        check("p5_rst_status", {BUSY, DONE, PASS, ERR_CNT}, 0);
        check("p5_rst_wdata", axi.WDATA, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        clear_slave();
        pulse_start();
        wait_done(3000, cyc);
        check("p5_cycles", 64'(cyc), 64'(EXP_CYC));
        check("p5_status", {BUSY, DONE, PASS}, 3'b011);
        check_mem("p5_mem_all");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/axi4_ram_tester.md
# axi4_ram_tester

AXI4 initiator that exercises the AXI4 SRAM slave from the master side. On a START pulse it writes a deterministic 64-bit pattern over a configurable address window in INCR bursts, then reads the window back and compares every beat. It reports BUSY, DONE, PASS and a saturating error count. It sits between the board-level test control logic and the AXI4 SRAM slave, on the same ACLK domain.

## Interface
- AXI4_AWIDTH, 32, address width
- AXI4_IDWIDTH, 4, ID width
- BASE_ADDR, 0, first byte address; must be aligned to BURST_LEN*8
- BURST_LEN, 16, beats per burst, 1..256; BURST_LEN*8 ≤ 4096
- NUM_BURSTS, 32, bursts per pass, 1..65535
- ACLK  in  1  clock, all logic rising-edge
- ARESETN  in  1  reset; synchronous, active-low
- START  in  1  one-cycle request; accepted only in IDLE or DONE
- BUSY  out  1  high from START acceptance until DONE
- DONE  out  1  level; high after the pass completes, cleared by next accepted START
- PASS  out  1  DONE & (ERR_CNT==0)
- ERR_CNT  out  16  saturating error count for the current pass
- AWID, AWADDR, AWLEN  out  IDW/AWIDTH/8  ID=0, burst address, BURST_LEN-1
- AWSIZE, AWBURST, AWCACHE, AWPROT, AWLOCK  out  3/2/4/3/2  constants 3'b011, 2'b01, 4'b0011, 3'b000, 2'b00
- AWVALID out 1; AWREADY in 1  write-address handshake
- WDATA out 64; WSTRB out 8 (always 8'hFF); WLAST out 1; WVALID out 1; WREADY in 1
- BID in IDW; BRESP in 2; BVALID in 1; BREADY out 1
- AR* outputs  out  same widths and constant values as AW* counterparts; ARVALID out 1; ARREADY in 1
- RID in IDW; RDATA in 64; RRESP in 2; RLAST in 1; RVALID in 1; RREADY out 1

## Operation
- FSM states: IDLE, AW, W, B, AR, R, DONE. Only one transaction is outstanding at any time.
- Global beat index g (32 bits) counts beats from 0 within a phase and resets to 0 at the start of each phase.
- Pattern: data(g) = {~g[31:0], g[31:0]}.
- Burst n address = BASE_ADDR + n*BURST_LEN*8, computed mod 2^AXI4_AWIDTH.
- IDLE/DONE -> AW on START: ERR_CNT cleared, DONE and PASS cleared, BUSY set, n=0, g=0.
- AW: AWVALID held until AWREADY, then -> W.
- W: WVALID held continuously. On each WVALID&WREADY, g and beat are incremented. WLAST is asserted on beat BURST_LEN-1; the WLAST handshake -> B.
- B: BREADY=1. On BVALID, BRESP!=0 or BID!=0 adds 1 error. Next state is AW for n+1, or AR (with n=0, g=0) after the last burst.
- AR: same as AW for the read channel, -> R.
- R: RREADY=1. On each RVALID, the beat is compared with data(g), with RRESP==0, with RID==0, and with RLAST==(beat==BURST_LEN-1). Any mismatch adds exactly 1 error for that beat. Expected last beat -> AR for the next burst, or DONE after the last burst.
- DONE: BUSY=0, DONE=1, PASS valid.
- ERR_CNT saturates at 16'hFFFF.
- START is ignored while BUSY.

## Timing
- Reset values: all VALIDs 0, BREADY 0, RREADY 0, WLAST 0, BUSY 0, DONE 0, PASS 0, ERR_CNT 0, address/data outputs 0, state IDLE.
- AWVALID rises the cycle after START is sampled.
- WVALID rises the cycle after the AW handshake.
- AWVALID for the next burst rises the cycle after the B handshake. AR/R follow the same rules.
- Zero-wait slave: write burst = 1 (AW) + BURST_LEN (W) + 1 (B) cycles minimum.
- A VALID, once raised, is not dropped and its payload does not change until the handshake.
- WREADY low: WDATA/WLAST are held.
- RLAST arriving early or late counts as an error on that beat. The burst still ends on the expected beat count.
- ARESETN low at any clock edge: all outputs return to reset values on that edge and the transaction is abandoned.

## Configuration
- AXI4_RAM_TESTER_RDCHK_EN defined: the read-back and compare phase (AR, R) is compiled in.
- AXI4_RAM_TESTER_RDCHK_EN undefined: AR and R are removed, and the last B goes directly to DONE. ARVALID and RREADY are tied 0, AR* payloads are tied 0, and only B errors are counted.

## Test plan
- Default parameters, zero-wait slave model of 512x64 -> 32 write bursts then 32 read bursts; DONE=1, PASS=1, ERR_CNT=0; memory word 5 = 64'hFFFFFFFA_00000005.
- Random AWREADY/WREADY/ARREADY/RVALID stalls -> identical memory contents, PASS=1, payload stable while VALID is high.
- Slave corrupts RDATA of read beat 37 -> ERR_CNT=1, PASS=0.
- Slave returns BRESP=2'b10 on burst 3 and RLAST a beat early on burst 0 -> ERR_CNT=2.
- START pulsed while BUSY, then ARESETN low mid-W -> the extra START has no effect; after reset, outputs are at reset values and a new START completes with PASS=1.
- Build without AXI4_RAM_TESTER_RDCHK_EN -> ARVALID stays 0; DONE is reached after the 32nd B handshake.
